// File: rtl/data_mem_ctrl.sv
// Multi-cycle data-memory controller for the MEM stage: accepts one load or store,
// holds the pipeline for LATENCY cycles, then pulses done for one cycle.
module data_mem_ctrl #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned AW      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        err
);

    localparam int unsigned DEPTH = 1 << AW;

    if (LATENCY < 2 || LATENCY > 15) begin : g_bad_latency
        $error("data_mem_ctrl: LATENCY must lie in 2..15");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [3:0]     cnt;
    logic           op_wr;
    logic [AW-1:0]  idx;
    logic [15:0]    mem [0:DEPTH-1];

    logic one_req;
    logic both_req;
    logic commit;

    assign one_req  = MemRead ^ MemWrite;
    assign both_req = MemRead & MemWrite;
    assign commit   = (state == BUSY) && (cnt == 4'd0);

    assign stall = (state == BUSY) || ((state == IDLE) && one_req);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            rdata <= 16'h0000;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (one_req) begin
                        cnt   <= 4'(LATENCY - 2);
                        state <= BUSY;
                    end else if (both_req) begin
                        err <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (!op_wr) begin
                            rdata <= mem[idx];
                        end
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Requests still asserted here are ignored; re-acceptance waits for IDLE.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Op type and word index are captured at acceptance only; later bus changes are ignored.
    always_ff @(posedge clk) begin
        if ((state == IDLE) && one_req && !rst) begin
            op_wr <= MemWrite;
            idx   <= addr[AW:1];
        end
    end

    // Storage is deliberately not reset; a reset during BUSY leaves state IDLE so no commit occurs.
    always_ff @(posedge clk) begin
        if (commit && op_wr) begin
            mem[idx] <= wdata;
        end
    end

    property p_req_stable;
        @(posedge clk) disable iff (rst)
            (state == BUSY) |-> ($stable(addr) && $stable(wdata) &&
                                 $stable(MemRead) && $stable(MemWrite));
    endproperty

    a_req_stable: assert property (p_req_stable)
        else $warning("data_mem_ctrl: requester changed request inputs while stalled");

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized bench for data_mem_ctrl with a cycle-timeline reference model and a few
// hand-computed literal expectations.
module tb_data_mem_ctrl;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [15:0] wdata = 16'h0000;
    logic [15:0] rdata;
    logic        stall;
    logic        done;
    logic        err;

    int checks = 0;
    int failures = 0;

    data_mem_ctrl #(.LATENCY(LAT), .AW(8)) dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
        .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: each access is a timeline measured in cycles since acceptance.
    logic [15:0] mmem [256];
    bit          mknown [256];
    logic [15:0] m_rdata = 16'h0000;
    bit          in_acc = 0;
    bit          acc_wr = 0;
    int          acc_start = 0;
    int          acc_idx = 0;
    bit          err_pend = 0;
    int          cyc = 0;
    bit          chk_en = 0;

    function automatic int word_of(input logic [15:0] a);
        return (int'(a) / 2) % 256;
    endfunction

    always @(negedge clk) begin
        bit          e_stall, e_done, e_err;
        logic [15:0] e_rdata;
        int          k;
        cyc++;
        e_done = 0;
        if (rst) begin
            in_acc   = 0;
            err_pend = 0;
            m_rdata  = 16'h0000;
            e_stall  = MemRead ^ MemWrite;
            e_err    = 0;
            e_rdata  = m_rdata;
        end else begin
            e_err    = err_pend;
            err_pend = 0;
            e_rdata  = m_rdata;
            if (in_acc) begin
                k       = cyc - acc_start;
                e_stall = (k < LAT);
                e_done  = (k == LAT);
                if (k == LAT - 1) begin
                    if (acc_wr) begin
                        mmem[acc_idx]   = wdata;
                        mknown[acc_idx] = 1;
                    end else begin
                        m_rdata = mmem[acc_idx];
                    end
                end
                if (k == LAT) in_acc = 0;
            end else begin
                e_stall = MemRead ^ MemWrite;
                if (e_stall) begin
                    in_acc    = 1;
                    acc_start = cyc;
                    acc_wr    = MemWrite;
                    acc_idx   = word_of(addr);
                end else if (MemRead && MemWrite) begin
                    err_pend = 1;
                end
            end
        end
        if (chk_en) begin
            chk("stall", 16'(stall), 16'(e_stall));
            chk("done", 16'(done), 16'(e_done));
            chk("err", 16'(err), 16'(e_err));
            chk("rdata", rdata, e_rdata);
        end
    end

    // Presents one request, holds it until done, and reports latency and rdata at done.
    task automatic do_req(input bit wr, input logic [15:0] a, input logic [15:0] d,
                          output int lat, output logic [15:0] rd);
        int n;
        @(posedge clk); #1;
        MemRead  = !wr;
        MemWrite = wr;
        addr     = a;
        wdata    = d;
        n = 0;
        rd = 16'h0000;
        while (n <= 40) begin
            @(negedge clk);
            if (done) break;
            n++;
        end
        if (n > 40) begin
            failures++;
            checks++;
            $display("FAIL timeout waiting for done addr=%h", a);
        end
        rd  = rdata;
        lat = n;
        @(posedge clk); #1;
        MemRead  = 0;
        MemWrite = 0;
    endtask

    initial begin
        int          lat;
        logic [15:0] rd;
        int          ndone;
        for (int i = 0; i < 256; i++) mknown[i] = 0;

        repeat (2) @(negedge clk);
        chk_en = 1;
        @(negedge clk);
        chk("reset_rdata", rdata, 16'h0000);
        chk("reset_done", 16'(done), 16'h0000);
        @(posedge clk); #1;
        rst = 0;

        do_req(1, 16'h0010, 16'hBEEF, lat, rd);
        chk("write_latency", 16'(lat), 16'd4);
        chk("model_mem_beef", mmem[8], 16'hBEEF);
        do_req(0, 16'h0010, 16'h0000, lat, rd);
        chk("read_beef", rd, 16'hBEEF);
        chk("read_latency", 16'(lat), 16'd4);

        do_req(1, 16'h0010, 16'h1234, lat, rd);
        do_req(0, 16'h0011, 16'h0000, lat, rd);
        chk("alias_bit0", rd, 16'h1234);
        do_req(0, 16'h0210, 16'h0000, lat, rd);
        chk("alias_wrap", rd, 16'h1234);

        // Both requests together in IDLE.
        @(posedge clk); #1;
        MemRead = 1; MemWrite = 1; addr = 16'h0010; wdata = 16'hDEAD;
        @(negedge clk);
        chk("both_stall", 16'(stall), 16'h0000);
        @(posedge clk); #1;
        MemRead = 0; MemWrite = 0;
        @(negedge clk);
        chk("both_err", 16'(err), 16'h0001);
        chk("both_done", 16'(done), 16'h0000);
        chk("both_rdata", rdata, 16'h1234);
        @(negedge clk);
        chk("both_err_gone", 16'(err), 16'h0000);
        do_req(0, 16'h0010, 16'h0000, lat, rd);
        chk("both_storage", rd, 16'h1234);

        // Reset during BUSY aborts a pending write.
        do_req(1, 16'h0020, 16'h5555, lat, rd);
        ndone = 0;
        @(posedge clk); #1;
        MemWrite = 1; addr = 16'h0020; wdata = 16'hAAAA;
        @(negedge clk); ndone += int'(done);
        @(posedge clk); #1;
        @(negedge clk); ndone += int'(done);
        @(posedge clk); #1;
        rst = 1; MemWrite = 0;
        @(negedge clk); ndone += int'(done);
        @(posedge clk); #1;
        rst = 0;
        repeat (3) begin @(negedge clk); ndone += int'(done); end
        chk("abort_no_done", 16'(ndone), 16'h0000);
        do_req(0, 16'h0020, 16'h0000, lat, rd);
        chk("abort_preserved", rd, 16'h5555);

        // Request held across DONE: one access per LAT+1 cycles.
        @(posedge clk); #1;
        MemRead = 1; addr = 16'h0010;
        ndone = 0;
        repeat (3 * (LAT + 1)) begin @(negedge clk); ndone += int'(done); end
        @(posedge clk); #1;
        MemRead = 0;
        chk("held_done_count", 16'(ndone), 16'd3);
        repeat (2) @(posedge clk);

        // Address and data changed mid-access: latched index, final wdata.
        do_req(1, 16'h0040, 16'h3333, lat, rd);
        @(posedge clk); #1;
        MemWrite = 1; addr = 16'h0030; wdata = 16'h1111;
        @(posedge clk); #1;
        addr = 16'h0040; wdata = 16'h2222;
        ndone = 0;
        while (!done && ndone < 20) begin @(negedge clk); ndone++; end
        @(posedge clk); #1;
        MemWrite = 0;
        do_req(0, 16'h0030, 16'h0000, lat, rd);
        chk("busy_change_latched", rd, 16'h2222);
        do_req(0, 16'h0040, 16'h0000, lat, rd);
        chk("busy_change_other", rd, 16'h3333);

        // Randomized traffic over a small word pool with aliasing address bits.
        for (int t = 0; t < 60; t++) begin
            int          w;
            bit          wr;
            logic [15:0] a;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            if ($urandom_range(0, 5) == 0) begin
                @(posedge clk); #1;
                MemRead = 1; MemWrite = 1;
                @(posedge clk); #1;
                MemRead = 0; MemWrite = 0;
            end
            w  = $urandom_range(0, 15);
            wr = ($urandom_range(0, 1) == 1) || !mknown[w];
            a  = 16'(($urandom_range(0, 127) << 9) | (w << 1) | $urandom_range(0, 1));
            do_req(wr, a, 16'($urandom), lat, rd);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter LATENCY, default 4, meaning the number of cycles from request acceptance to completion; legal range 2..15.
REQ-002 Parameter AW, default 8, meaning the word-address width; storage is 2^AW x 16-bit words.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 MemRead  input  1  read request from the MEM-stage control decode.
REQ-006 MemWrite  input  1  write request from the MEM-stage control decode.
REQ-007 addr  input  16  byte address; bits [AW:1] select the word, bit 0 and bits [15:AW+1] are ignored.
REQ-008 wdata  input  16  store data, sampled at the commit edge.
REQ-009 rdata  output  16  registered load data, valid while done=1 for a read.
REQ-010 stall  output  1  hold-pipeline indication, combinational from state and requests.
REQ-011 done  output  1  one-cycle completion pulse, registered.
REQ-012 err  output  1  one-cycle pulse flagging an illegal request, registered.

Function
REQ-013 FSM states SHALL be IDLE, BUSY and DONE, with a 4-bit down-counter cnt.
REQ-014 IDLE, exactly one of MemRead/MemWrite high at the edge: latch op type and word index, load cnt=LATENCY-2, go to BUSY; if LATENCY=2, go directly to the commit edge after one BUSY cycle.
REQ-015 BUSY, cnt!=0: decrement cnt; stay in BUSY.
REQ-016 BUSY, cnt==0 (commit edge): a write stores wdata at the latched index; a read loads rdata from the latched index; set done=1; go to DONE.
REQ-017 DONE: done=1 for exactly this cycle; all requests ignored; next state IDLE, done returns 0.
REQ-018 stall SHALL be 1 when in BUSY, or when in IDLE with exactly one request high; 0 in DONE and otherwise.
REQ-019 A request presented in cycle 0 SHALL give stall=1 for cycles 0..LATENCY-1 and done=1 with stall=0 in cycle LATENCY.
REQ-020 The requester SHALL hold MemRead, MemWrite, addr and wdata stable while stall=1; changes during BUSY have no effect on the latched op or index.
REQ-021 MemRead and MemWrite both high in IDLE: no access, no state change, stall=0, err=1 in the following cycle only.
REQ-022 rdata SHALL change only at a read commit edge or at reset; a write leaves rdata unchanged.
REQ-023 Addresses differing only in bit 0 or in bits above AW SHALL alias the same word (wrap-around).
REQ-024 Back-to-back requests: the earliest acceptance of a new request is the IDLE cycle after DONE, giving a minimum of LATENCY+1 cycles per access.

Reset
REQ-025 While rst=1: state=IDLE, cnt=0, rdata=0, done=0, err=0, stall driven from IDLE rules.
REQ-026 Reset asserted during BUSY SHALL abort the access; a pending write SHALL NOT commit.
REQ-027 Storage contents are not cleared by reset; contents are undefined until written.

Verification
REQ-028 Write 0xBEEF to addr 0x0010, LATENCY=4 -> stall=1 in cycles 0-3, done=1 and stall=0 in cycle 4; a subsequent read of 0x0010 returns rdata=0xBEEF with done.
REQ-029 Read of addr 0x0011 after writing 0x1234 to 0x0010 -> rdata=0x1234 (bit-0 alias); with AW=8, a read of 0x0210 also returns 0x1234.
REQ-030 MemRead=MemWrite=1 in IDLE -> err=1 for one cycle, stall=0, done=0, storage and rdata unchanged.
REQ-031 Write of 0xAAAA to 0x0020, rst pulsed in cycle 2 -> state IDLE, done never asserted; a later read of 0x0020 does not return 0xAAAA (prior value preserved).
REQ-032 Request held high continuously across DONE -> exactly one access per LATENCY+1 cycles; no double-accept in the DONE cycle.
REQ-033 addr/wdata changed during BUSY -> commit uses the latched index and the final held wdata; a requester-rule violation is flagged by an assertion.
